simple_axi_write_master: RTL and testbench

- Single-outstanding AXI4 write master that drives the write channels (AW, W, B) of the simple_axi interface.
- Accepts a burst command (address, beat count) and a beat data stream from the upstream user logic.
- Issues one INCR burst of 4-byte beats and reports the write response back upstream.
- The interface ties off size, burst, lock, cache, prot, region and qos; this block drives only the remaining write-channel signals.

---
 rtl/simple_axi_write_master.sv | 207 ++++++++++++++++++++
 tb/tb_simple_axi_write_master.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/simple_axi_write_master.sv
`default_nettype none
// ============================================================================
// Module   : simple_axi_write_master
// Purpose  : Single-outstanding AXI4 write master. Takes a burst command and
//            a beat stream, issues one INCR burst of 4-byte beats on AW/W and
//            returns the B response upstream as a done pulse.
// Revision : 1.0 - initial release
// ============================================================================
module simple_axi_write_master #(
    parameter int C_AXI_ADDR_WIDTH = 32,
    parameter int C_AXI_DATA_WIDTH = 32
) (
    input  logic                          aclk,
    input  logic                          arstn,
    input  logic                          cmd_valid,
    output logic                          cmd_ready,
    input  logic [C_AXI_ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [7:0]                    cmd_len,
    input  logic                          din_valid,
    output logic                          din_ready,
    input  logic [C_AXI_DATA_WIDTH-1:0]   din_data,
    input  logic [C_AXI_DATA_WIDTH/8-1:0] din_strb,
    output logic                          done,
    output logic [1:0]                    done_resp,
    output logic                          busy,
    output logic [C_AXI_ADDR_WIDTH-1:0]   axi_awaddr,
    output logic [7:0]                    axi_awlen,
    output logic                          axi_awvalid,
    input  logic                          axi_awready,
    output logic [C_AXI_DATA_WIDTH-1:0]   axi_wdata,
    output logic [C_AXI_DATA_WIDTH/8-1:0] axi_wstrb,
    output logic                          axi_wlast,
    output logic                          axi_wvalid,
    input  logic                          axi_wready,
    input  logic [1:0]                    axi_bresp,
    input  logic                          axi_bvalid,
    output logic                          axi_bready
);

    // Beats are fixed at 4 bytes, so any other data width is meaningless.
    generate
        if (C_AXI_DATA_WIDTH != 32) begin : g_width_check
            $error("simple_axi_write_master supports only C_AXI_DATA_WIDTH = 32");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_XFER = 2'd1,
        S_RESP = 2'd2,
        S_ERR  = 2'd3
    } state_t;

    state_t                        state_q, state_d;
    logic [C_AXI_ADDR_WIDTH-1:0]   awaddr_q, awaddr_d;
    logic [7:0]                    awlen_q, awlen_d;
    logic                          awvalid_q, awvalid_d;
    logic                          bready_q, bready_d;
    logic                          done_q, done_d;
    logic [1:0]                    done_resp_q, done_resp_d;
    logic                          busy_q, busy_d;
    logic [7:0]                    beat_cnt_q, beat_cnt_d;
    logic                          aw_done_q, aw_done_d;
    logic                          w_done_q, w_done_d;

    logic [C_AXI_ADDR_WIDTH-1:0]   addr_aligned;
    logic [9:0]                    beats;
    logic [12:0]                   burst_end;
    logic                          cross_4k;
    logic                          w_open;
    logic                          aw_hs;
    logic                          w_hs;
    logic                          last_hs;

    // Word-align the start address and test whether the burst leaves its 4 KB page.
    always_comb begin
        addr_aligned = cmd_addr & {{(C_AXI_ADDR_WIDTH-2){1'b1}}, 2'b00};
        beats        = {2'b00, cmd_len} + 10'd1;
        burst_end    = {1'b0, addr_aligned[11:0]} + {1'b0, beats, 2'b00};
        cross_4k     = (burst_end > 13'd4096);
    end

    // W channel is a direct pass-through while beats remain in the burst.
    always_comb begin
        w_open      = (state_q == S_XFER) && !w_done_q;
        axi_wvalid  = w_open && din_valid;
        din_ready   = w_open && axi_wready;
        axi_wdata   = din_data;
        axi_wstrb   = din_strb;
        axi_wlast   = w_open && (beat_cnt_q == awlen_q);
        aw_hs       = awvalid_q && axi_awready;
        w_hs        = axi_wvalid && axi_wready;
        last_hs     = w_hs && axi_wlast;
        // Held low during the done cycle so back-to-back commands start one cycle after done.
        cmd_ready   = (state_q == S_IDLE) && !done_q;
    end

    // Next-state and next-output computation for the burst controller.
    always_comb begin
        state_d     = state_q;
        awaddr_d    = awaddr_q;
        awlen_d     = awlen_q;
        awvalid_d   = awvalid_q;
        bready_d    = bready_q;
        done_d      = 1'b0;
        done_resp_d = done_resp_q;
        busy_d      = busy_q;
        beat_cnt_d  = beat_cnt_q;
        aw_done_d   = aw_done_q;
        w_done_d    = w_done_q;
        unique case (state_q)
            S_IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    if (cross_4k) begin
                        state_d     = S_ERR;
                        done_d      = 1'b1;
                        done_resp_d = 2'b10;
                    end else begin
                        state_d    = S_XFER;
                        awvalid_d  = 1'b1;
                        awaddr_d   = addr_aligned;
                        awlen_d    = cmd_len;
                        busy_d     = 1'b1;
                        beat_cnt_d = 8'd0;
                        aw_done_d  = 1'b0;
                        w_done_d   = 1'b0;
                    end
                end
            end
            S_XFER: begin
                if (aw_hs) begin
                    awvalid_d = 1'b0;
                    aw_done_d = 1'b1;
                end
                if (w_hs) begin
                    if (axi_wlast) begin
                        beat_cnt_d = 8'd0;
                        w_done_d   = 1'b1;
                    end else begin
                        beat_cnt_d = beat_cnt_q + 8'd1;
                    end
                end
                // AW and the last W beat may complete in either order.
                if ((aw_done_q || aw_hs) && (w_done_q || last_hs)) begin
                    state_d   = S_RESP;
                    bready_d  = 1'b1;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                end
            end
            S_RESP: begin
                if (bready_q && axi_bvalid) begin
                    state_d     = S_IDLE;
                    done_d      = 1'b1;
                    done_resp_d = axi_bresp;
                    busy_d      = 1'b0;
                    bready_d    = 1'b0;
                end
            end
            S_ERR: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and registered outputs; reset abandons any burst in flight.
    always_ff @(posedge aclk or negedge arstn) begin
        if (!arstn) begin
            state_q     <= S_IDLE;
            awaddr_q    <= '0;
            awlen_q     <= 8'd0;
            awvalid_q   <= 1'b0;
            bready_q    <= 1'b0;
            done_q      <= 1'b0;
            done_resp_q <= 2'b00;
            busy_q      <= 1'b0;
            beat_cnt_q  <= 8'd0;
            aw_done_q   <= 1'b0;
            w_done_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            awaddr_q    <= awaddr_d;
            awlen_q     <= awlen_d;
            awvalid_q   <= awvalid_d;
            bready_q    <= bready_d;
            done_q      <= done_d;
            done_resp_q <= done_resp_d;
            busy_q      <= busy_d;
            beat_cnt_q  <= beat_cnt_d;
            aw_done_q   <= aw_done_d;
            w_done_q    <= w_done_d;
        end
    end

    assign axi_awaddr  = awaddr_q;
    assign axi_awlen   = awlen_q;
    assign axi_awvalid = awvalid_q;
    assign axi_bready  = bready_q;
    assign done        = done_q;
    assign done_resp   = done_resp_q;
    assign busy        = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_simple_axi_write_master.sv
`default_nettype none
// ============================================================================
// Module   : tb_simple_axi_write_master
// Purpose  : Directed self-checking bench for simple_axi_write_master with a
//            simple AW/W/B slave and an upstream beat source.
// Revision : 1.0 - initial release
// ============================================================================
module tb_simple_axi_write_master;

    logic        aclk;
    logic        arstn;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [31:0] cmd_addr;
    logic [7:0]  cmd_len;
    logic        din_valid;
    logic        din_ready;
    logic [31:0] din_data;
    logic [3:0]  din_strb;
    logic        done;
    logic [1:0]  done_resp;
    logic        busy;
    logic [31:0] axi_awaddr;
    logic [7:0]  axi_awlen;
    logic        axi_awvalid;
    logic        axi_awready;
    logic [31:0] axi_wdata;
    logic [3:0]  axi_wstrb;
    logic        axi_wlast;
    logic        axi_wvalid;
    logic        axi_wready;
    logic [1:0]  axi_bresp;
    logic        axi_bvalid;
    logic        axi_bready;

    int n_assert = 0;
    int n_fail   = 0;

    simple_axi_write_master #(
        .C_AXI_ADDR_WIDTH(32),
        .C_AXI_DATA_WIDTH(32)
    ) dut (
        .aclk(aclk), .arstn(arstn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .din_valid(din_valid), .din_ready(din_ready),
        .din_data(din_data), .din_strb(din_strb),
        .done(done), .done_resp(done_resp), .busy(busy),
        .axi_awaddr(axi_awaddr), .axi_awlen(axi_awlen),
        .axi_awvalid(axi_awvalid), .axi_awready(axi_awready),
        .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb), .axi_wlast(axi_wlast),
        .axi_wvalid(axi_wvalid), .axi_wready(axi_wready),
        .axi_bresp(axi_bresp), .axi_bvalid(axi_bvalid), .axi_bready(axi_bready)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    // Observation state, updated on the falling edge (values that will be
    // sampled by the next rising edge).
    int          cyc = 0;
    int          aw_cnt, w_cnt, last_cnt, done_cnt, busy_cnt;
    int          acc_cyc, aw_cyc, w_cyc, b_cyc, done_cyc;
    logic [31:0] aw_addr_seen;
    logic [7:0]  aw_len_seen;
    logic [1:0]  done_resp_seen;
    bit          din_ready_seen;
    logic [31:0] exp_base;
    int          exp_len;
    bit          strb_mode;
    bit          prev_wstall, prev_awstall;
    logic [31:0] prev_wdata, prev_awaddr;
    logic [3:0]  prev_wstrb;
    logic [7:0]  prev_awlen;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] strb_of(input int i);
        logic [3:0] s;
        s = strb_mode ? i[3:0] : 4'hF;
        return s;
    endfunction

    task automatic clr();
        aw_cnt = 0; w_cnt = 0; last_cnt = 0; done_cnt = 0; busy_cnt = 0;
        acc_cyc = 0; aw_cyc = 0; w_cyc = 0; b_cyc = 0; done_cyc = 0;
        din_ready_seen = 0;
    endtask

    // Bus monitor with per-beat and per-cycle protocol checks.
    always @(negedge aclk) begin
        cyc++;
        if (!arstn) begin
            prev_wstall  = 0;
            prev_awstall = 0;
        end else begin
            if (prev_awstall) begin
                chk("aw_hold_valid", axi_awvalid, 1);
                chk("aw_hold_addr", axi_awaddr, prev_awaddr);
                chk("aw_hold_len", axi_awlen, prev_awlen);
            end
            prev_awstall = axi_awvalid && !axi_awready;
            prev_awaddr  = axi_awaddr;
            prev_awlen   = axi_awlen;
            if (axi_awvalid && axi_awready) begin
                aw_cnt++; aw_addr_seen = axi_awaddr; aw_len_seen = axi_awlen; aw_cyc = cyc;
            end
            if (prev_wstall) begin
                chk("w_hold_valid", axi_wvalid, 1);
                chk("w_hold_data", axi_wdata, prev_wdata);
                chk("w_hold_strb", axi_wstrb, prev_wstrb);
            end
            prev_wstall = axi_wvalid && !axi_wready;
            prev_wdata  = axi_wdata;
            prev_wstrb  = axi_wstrb;
            if (w_cnt == exp_len + 1)
                chk("no_beat_after_last", axi_wvalid | din_ready, 0);
            if (axi_wvalid && axi_wready) begin
                chk("wdata", axi_wdata, exp_base + w_cnt);
                chk("wstrb", axi_wstrb, strb_of(w_cnt));
                chk("wlast", axi_wlast, (w_cnt == exp_len));
                if (axi_wlast) last_cnt++;
                w_cnt++; w_cyc = cyc;
            end
            if (axi_bvalid) chk("bvalid_after_last_beat", w_cnt, exp_len + 1);
            if (axi_bvalid && axi_bready) b_cyc = cyc;
            if (cmd_valid && cmd_ready) acc_cyc = cyc;
            if (busy) begin
                busy_cnt++;
                chk("cmd_ready_while_busy", cmd_ready, 0);
            end
            if (done) begin
                done_cnt++; done_cyc = cyc; done_resp_seen = done_resp;
                chk("cmd_ready_on_done", cmd_ready, 0);
            end
            if (din_ready) din_ready_seen = 1;
        end
    end

    // Present a command and hold it until it is accepted.
    task automatic issue(input logic [31:0] addr, input int len);
        int g;
        cmd_addr = addr; cmd_len = 8'(len); cmd_valid = 1'b1;
        g = 0;
        do begin @(negedge aclk); g++; end while (!cmd_ready && g < 20);
        if (g >= 20) chk("cmd_accept_timeout", cmd_ready, 1);
        @(posedge aclk); #1;
        cmd_valid = 1'b0;
    endtask

    // Upstream beat source; optional random stalls on din_valid and wready.
    task automatic drive_data(input int len, input bit stall, input bit keep);
        int  i, g;
        bit  hs;
        i = 0; g = 0;
        while (i <= len && g < 5000) begin
            if (!din_valid) din_valid = stall ? ($urandom_range(0, 3) != 0) : 1'b1;
            din_data   = exp_base + i;
            din_strb   = strb_of(i);
            axi_wready = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
            @(negedge aclk);
            hs = din_valid && din_ready;
            if (hs) i++;
            @(posedge aclk); #1;
            if (hs) din_valid = 1'b0;
            g++;
        end
        if (g >= 5000) chk("data_timeout", i, len + 1);
        din_valid = keep;
    endtask

    // AW slave: ready immediately, or delay cycles after awvalid appears.
    task automatic drive_aw(input int delay);
        int g;
        if (delay == 0) begin
            axi_awready = 1'b1;
        end else begin
            axi_awready = 1'b0;
            g = 0;
            while (!axi_awvalid && g < 200) begin @(negedge aclk); g++; end
            repeat (delay) @(posedge aclk);
            #1 axi_awready = 1'b1;
        end
        g = 0;
        while (aw_cnt == 0 && g < 200) begin @(posedge aclk); g++; end
        #1 axi_awready = 1'b0;
        chk("aw_handshakes", aw_cnt, 1);
    endtask

    // B slave: responds only once AW and every W beat have been seen.
    task automatic drive_b(input int len, input logic [1:0] resp);
        int g;
        axi_bvalid = 1'b0;
        g = 0;
        while (!(w_cnt == len + 1 && aw_cnt == 1) && g < 5000) begin @(posedge aclk); g++; end
        if (g >= 5000) chk("b_wait_timeout", w_cnt, len + 1);
        #1 axi_bvalid = 1'b1; axi_bresp = resp;
        g = 0;
        do begin @(negedge aclk); g++; end while (!axi_bready && g < 50);
        if (g >= 50) chk("bready_timeout", axi_bready, 1);
        @(posedge aclk); #1;
        axi_bvalid = 1'b0; axi_bresp = 2'b00;
    endtask

    task automatic run_cmd(input string tag, input logic [31:0] addr, input int len,
                           input int aw_delay, input bit stall, input bit keep,
                           input logic [1:0] resp, input logic [31:0] base);
        int g;
        clr();
        exp_base = base; exp_len = len;
        issue(addr, len);
        fork
            drive_data(len, stall, keep);
            drive_aw(aw_delay);
            drive_b(len, resp);
        join
        g = 0;
        while (done_cnt == 0 && g < 50) begin @(posedge aclk); g++; end
        repeat (2) @(posedge aclk);
        #1;
        din_valid = 1'b0;
        chk({tag, "_done_pulses"}, done_cnt, 1);
        chk({tag, "_done_resp"}, done_resp_seen, resp);
        chk({tag, "_done_resp_hold"}, done_resp, resp);
        chk({tag, "_awaddr"}, aw_addr_seen, addr & 32'hFFFF_FFFC);
        chk({tag, "_awlen"}, aw_len_seen, len);
        chk({tag, "_beats"}, w_cnt, len + 1);
        chk({tag, "_wlast_count"}, last_cnt, 1);
        chk({tag, "_busy_span"}, busy_cnt, b_cyc - acc_cyc);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        arstn = 1'b0; cmd_valid = 1'b0; cmd_addr = '0; cmd_len = '0;
        din_valid = 1'b0; din_data = '0; din_strb = '0;
        axi_awready = 1'b0; axi_wready = 1'b0; axi_bresp = 2'b00; axi_bvalid = 1'b0;
        exp_base = '0; exp_len = 0; strb_mode = 0;
        clr();

        // Reset values.
        repeat (3) @(posedge aclk);
        #1;
        chk("rst_awvalid", axi_awvalid, 0);
        chk("rst_bready", axi_bready, 0);
        chk("rst_done", done, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done_resp", done_resp, 2'b00);
        chk("rst_awaddr", axi_awaddr, 32'h0);
        chk("rst_awlen", axi_awlen, 8'h0);
        arstn = 1'b1;
        @(posedge aclk); #1;
        chk("idle_cmd_ready", cmd_ready, 1);
        chk("idle_din_ready", din_ready, 0);

        // 1: zero-wait 4-beat burst at 0x1000.
        run_cmd("t1", 32'h1000, 3, 0, 0, 0, 2'b00, 32'h0000_00A0);
        chk("t1_busy_cycles", busy_cnt, 5);
        chk("t1_done_latency", done_cyc - acc_cyc, 6);

        // 2: single beat, unaligned address, AW delayed past the W beat.
        run_cmd("t2", 32'h2003, 0, 5, 0, 1, 2'b00, 32'h0000_0B00);
        chk("t2_w_before_aw", (w_cyc < aw_cyc), 1);
        chk("t2_done_after_aw", (done_cyc > aw_cyc), 1);
        chk("t2_done_after_b", (done_cyc > b_cyc), 1);

        // 3: burst ending exactly at the 4 KB boundary is legal.
        run_cmd("t3", 32'h0FF0, 3, 0, 0, 0, 2'b00, 32'hF000_0000);

        // 4: one beat more crosses 4 KB and is rejected without bus activity.
        clr();
        exp_len = 4;
        din_valid = 1'b1; axi_wready = 1'b1; axi_awready = 1'b1;
        issue(32'h0FF0, 4);
        repeat (6) @(posedge aclk);
        #1;
        chk("t4_aw_handshakes", aw_cnt, 0);
        chk("t4_w_handshakes", w_cnt, 0);
        chk("t4_din_ready_seen", din_ready_seen, 0);
        chk("t4_busy_cycles", busy_cnt, 0);
        chk("t4_done_pulses", done_cnt, 1);
        chk("t4_done_resp", done_resp_seen, 2'b10);
        chk("t4_done_latency", done_cyc - acc_cyc, 1);
        din_valid = 1'b0; axi_wready = 1'b0; axi_awready = 1'b0;

        // 5: 256-beat burst with random stalls and SLVERR response.
        strb_mode = 1;
        run_cmd("t5", 32'h0000_4000, 255, 0, 1, 0, 2'b10, 32'h5A00_0000);
        strb_mode = 0;

        // 6: reset asserted after beat 2 of 8, then a clean restart.
        clr();
        exp_base = 32'hC0DE_0000; exp_len = 7;
        axi_awready = 1'b1; axi_wready = 1'b1;
        din_strb = 4'hF; din_valid = 1'b1;
        issue(32'h3000, 7);
        begin
            int g;
            g = 0;
            while (w_cnt < 2 && g < 50) begin
                din_data = exp_base + w_cnt;
                @(posedge aclk); #1;
                g++;
            end
        end
        chk("t6_beats_before_reset", w_cnt, 2);
        arstn = 1'b0;
        #1;
        chk("t6_rst_busy", busy, 0);
        chk("t6_rst_wvalid", axi_wvalid, 0);
        chk("t6_rst_din_ready", din_ready, 0);
        chk("t6_rst_awvalid", axi_awvalid, 0);
        chk("t6_rst_awaddr", axi_awaddr, 32'h0);
        chk("t6_rst_awlen", axi_awlen, 8'h0);
        chk("t6_rst_done_resp", done_resp, 2'b00);
        chk("t6_rst_cmd_ready", cmd_ready, 1);
        din_valid = 1'b0; axi_awready = 1'b0; axi_wready = 1'b0;
        @(posedge aclk); #1;
        arstn = 1'b1;
        @(posedge aclk); #1;
        run_cmd("t6_restart", 32'h3000, 1, 0, 0, 0, 2'b01, 32'hBEEF_0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
